// File: rtl/cos_arbiter_if.sv
// rtl/cos_arbiter_if.sv - request, ROM and response signals shared by cos_arbiter and its environment
// req_sin exists only when COS_ARB_SIN_EN is defined.
interface cos_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [12*N_REQ-1:0] req_angle;
  logic [N_REQ-1:0]    req_ready;
`ifdef COS_ARB_SIN_EN
  logic [N_REQ-1:0]    req_sin;
`endif
  logic [11:0]         rom_angle;
  logic [15:0]         rom_result;
  logic                resp_valid;
  logic                resp_ready;
  logic [15:0]         resp_data;
  logic [ID_W-1:0]     resp_id;

`ifdef COS_ARB_SIN_EN
  modport master (
    output req_valid, req_angle, req_sin, rom_result, resp_ready,
    input  req_ready, rom_angle, resp_valid, resp_data, resp_id
  );
  modport slave (
    input  req_valid, req_angle, req_sin, rom_result, resp_ready,
    output req_ready, rom_angle, resp_valid, resp_data, resp_id
  );
`else
  modport master (
    output req_valid, req_angle, rom_result, resp_ready,
    input  req_ready, rom_angle, resp_valid, resp_data, resp_id
  );
  modport slave (
    input  req_valid, req_angle, rom_result, resp_ready,
    output req_ready, rom_angle, resp_valid, resp_data, resp_id
  );
`endif
endinterface

// File: rtl/cos_arbiter.sv
// rtl/cos_arbiter.sv - round-robin sharing of one combinational cos ROM between N_REQ requesters
// Define COS_ARB_SIN_EN to add a per-request sin option (angle reflected about 90 degrees).
module cos_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic         clk,
  input  logic         rst,
  cos_arbiter_if.slave bus
);
  logic            a_valid;
  logic [ID_W-1:0] a_id;
  logic [ID_W-1:0] last;
  logic [11:0]     rom_angle_q;
  logic            resp_valid_q;
  logic [15:0]     resp_data_q;
  logic [ID_W-1:0] resp_id_q;

  logic            a_load;
  logic            b_load;
  logic            found;
  logic            accept;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] cand;
  int              cand_i;
  logic [11:0]     win_angle;
  logic [N_REQ-1:0] ready_c;
  logic [11:0]     angles [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_angle
    assign angles[k] = bus.req_angle[12*k +: 12];
  end

  assign b_load = a_valid && (!resp_valid_q || bus.resp_ready);
  assign a_load = !a_valid || b_load;

  // Search starts one past the last accepted requester so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    cand_i = 0;
    cand   = '0;
    for (int s = 1; s <= N_REQ; s++) begin
      cand_i = (int'(last) + s) % N_REQ;
      cand   = ID_W'(cand_i);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_angle = angles[win];
`ifdef COS_ARB_SIN_EN
    if (bus.req_sin[win]) begin
      win_angle = 12'h400 - angles[win];
    end
`endif
  end

  assign accept = found && a_load && !rst;

  always_comb begin
    ready_c = '0;
    if (accept) begin
      ready_c[win] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid      <= 1'b0;
      a_id         <= '0;
      last         <= ID_W'(N_REQ - 1);
      rom_angle_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      if (a_load) begin
        if (accept) begin
          rom_angle_q <= win_angle;
          a_id        <= win;
          a_valid     <= 1'b1;
          last        <= win;
        end else begin
          a_valid <= 1'b0;
        end
      end
      // B refills from A whenever it is empty or being drained this edge.
      if (b_load) begin
        resp_data_q  <= bus.rom_result;
        resp_id_q    <= a_id;
        resp_valid_q <= 1'b1;
      end else if (bus.resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.rom_angle  = rom_angle_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
endmodule

// File: tb/tb_cos_arbiter.sv
// tb/tb_cos_arbiter.sv - directed bench for cos_arbiter with a queue-based reference model
// Covers the sin option when COS_ARB_SIN_EN is defined.
module tb_cos_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  function automatic logic [15:0] rom_fn(input logic [11:0] a);
    return {a[3:0] ^ 4'h5, a};
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cos_arbiter_if #(.N_REQ(N), .ID_W(IDW)) bus ();
  cos_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  assign bus.rom_result = rom_fn(bus.rom_angle);

  int total = 0;
  int bad   = 0;
  int acc_cnt [N];
  int acc_base [N];
  int acc_total = 0;
  int ids [$];
  logic [11:0] base [N];
  logic [N-1:0] sin_mask = '0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [11:0]    ang;
    logic           in_b;
  } item_t;
  item_t q [$];
  int             m_last = N - 1;
  logic [11:0]    m_rom  = '0;
  logic [15:0]    m_data = '0;
  logic [IDW-1:0] m_id   = '0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: in-flight items in acceptance order; the front item is in B once it has moved there.
  always @(negedge clk) begin
    bit b_full, a_full, b_move, can_acc, found;
    int win;
    logic [N-1:0] e_ready;
    logic [11:0] ang;
    item_t it;
    b_full  = q.size() > 0 && q[0].in_b;
    a_full  = q.size() > 0 && !q[q.size()-1].in_b;
    b_move  = a_full && (!b_full || bus.resp_ready);
    can_acc = !a_full || b_move;
    found = 0;
    win   = 0;
    for (int s = 1; s <= N; s++) begin
      if (!found && bus.req_valid[(m_last + s) % N]) begin
        found = 1;
        win   = (m_last + s) % N;
      end
    end
    e_ready = '0;
    if (!rst && can_acc && found) e_ready[win] = 1'b1;
    chk("req_ready",  16'(bus.req_ready),  16'(e_ready));
    chk("resp_valid", 16'(bus.resp_valid), 16'(b_full));
    chk("resp_data",  bus.resp_data,       m_data);
    chk("resp_id",    16'(bus.resp_id),    16'(m_id));
    chk("rom_angle",  16'(bus.rom_angle),  16'(m_rom));

    if (bus.resp_valid && bus.resp_ready) ids.push_back(int'(bus.resp_id));
    for (int k = 0; k < N; k++) begin
      if (bus.req_valid[k] && bus.req_ready[k]) begin
        acc_cnt[k]++;
        acc_total++;
      end
    end

    if (rst) begin
      q.delete();
      m_last = N - 1;
      m_rom  = '0;
      m_data = '0;
      m_id   = '0;
    end else begin
      if (b_full && bus.resp_ready) void'(q.pop_front());
      if (b_move) begin
        it = q[0];
        it.in_b = 1'b1;
        q[0] = it;
        m_data = rom_fn(it.ang);
        m_id   = it.id;
      end
      if (e_ready != '0) begin
        ang = bus.req_angle[win*12 +: 12];
`ifdef COS_ARB_SIN_EN
        if (bus.req_sin[win]) ang = 12'h400 - ang;
`endif
        it.id   = IDW'(win);
        it.ang  = ang;
        it.in_b = 1'b0;
        q.push_back(it);
        m_last = win;
        m_rom  = ang;
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic rr, input int n);
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < N; k++)
        bus.req_angle[k*12 +: 12] = base[k] + 12'(256 * (acc_cnt[k] - acc_base[k]));
      bus.req_valid  = v;
      bus.resp_ready = rr;
`ifdef COS_ARB_SIN_EN
      bus.req_sin = sin_mask;
`endif
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_base(input int k, input logic [11:0] val);
    base[k]     = val;
    acc_base[k] = acc_cnt[k];
  endtask

  task automatic set_fair_bases();
    for (int k = 0; k < N; k++) set_base(k, 12'(16 * k));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, 1'b1, 1);
    rst = 1'b0;
  endtask

  logic [N-1:0] tv [10] = '{4'b0101, 4'b1111, 4'b0011, 4'b1000, 4'b1110,
                            4'b0001, 4'b1111, 4'b0110, 4'b1010, 4'b1111};
  logic         tr [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int s0, a0;
    for (int k = 0; k < N; k++) begin
      acc_cnt[k]  = 0;
      acc_base[k] = 0;
      base[k]     = '0;
    end
    bus.req_valid  = '0;
    bus.req_angle  = '0;
    bus.resp_ready = 1'b1;
`ifdef COS_ARB_SIN_EN
    bus.req_sin = '0;
`endif
    set_fair_bases();

    // reset with all requesters valid
    rst = 1'b1;
    drive(4'hF, 1'b1, 1);
    chk("rst_ready", 16'(bus.req_ready), 16'h0);
    chk("rst_resp_valid", 16'(bus.resp_valid), 16'h0);
    chk("rst_rom_angle", 16'(bus.rom_angle), 16'h0);
    drive(4'hF, 1'b1, 1);
    chk("rst_ready2", 16'(bus.req_ready), 16'h0);
    rst = 1'b0;
    #1;
    chk("first_grant", 16'(bus.req_ready), 16'h0001);
    drive(4'hF, 1'b1, 1);
    drive('0, 1'b1, 3);

    // single request from requester 2
    set_base(2, 12'h123);
    drive(4'b0100, 1'b1, 1);
    chk("single_rom_angle", 16'(bus.rom_angle), 16'h0123);
    drive('0, 1'b1, 1);
    chk("single_valid", 16'(bus.resp_valid), 16'h1);
    chk("single_id", 16'(bus.resp_id), 16'h2);
    chk("single_data", bus.resp_data, 16'h6123);
    drive('0, 1'b1, 2);
    chk("single_drained", 16'(bus.resp_valid), 16'h0);

    // fairness under full load
    do_reset();
    set_fair_bases();
    s0 = ids.size();
    drive(4'hF, 1'b1, 12);
    drive('0, 1'b1, 3);
    chk("fair_count", 16'(ids.size() - s0), 16'd12);
    for (int i = 0; i < 12 && s0 + i < ids.size(); i++)
      chk("fair_id", 16'(ids[s0+i]), 16'(i % 4));

    // backpressure from empty pipeline
    do_reset();
    set_fair_bases();
    s0 = ids.size();
    a0 = acc_total;
    drive(4'hF, 1'b0, 5);
    chk("bp_accepts", 16'(acc_total - a0), 16'd2);
    chk("bp_ready", 16'(bus.req_ready), 16'h0);
    chk("bp_resp_id", 16'(bus.resp_id), 16'h0);
    chk("bp_resp_data", bus.resp_data, 16'h5000);
    chk("bp_rom_angle", 16'(bus.rom_angle), 16'h0010);
    drive(4'hF, 1'b1, 8);
    drive('0, 1'b1, 3);
    chk("bp_count", 16'(ids.size() - s0), 16'd10);
    for (int i = 0; i < 10 && s0 + i < ids.size(); i++)
      chk("bp_id", 16'(ids[s0+i]), 16'(i % 4));

    // reset with A and B full
    drive(4'hF, 1'b1, 4);
    rst = 1'b1;
    drive(4'hF, 1'b1, 1);
    chk("midrst_valid", 16'(bus.resp_valid), 16'h0);
    chk("midrst_rom", 16'(bus.rom_angle), 16'h0);
    rst = 1'b0;
    s0 = ids.size();
    drive('0, 1'b1, 4);
    chk("midrst_no_stale", 16'(ids.size() - s0), 16'd0);

    // lone requester
    a0 = acc_total;
    drive(4'b1000, 1'b1, 6);
    chk("lone_accepts", 16'(acc_total - a0), 16'd6);
    drive('0, 1'b1, 3);

    // mixed valid patterns and backpressure
    for (int i = 0; i < 10; i++) drive(tv[i], tr[i], 1);
    drive('0, 1'b1, 4);

`ifdef COS_ARB_SIN_EN
    sin_mask = 4'b0010;
    set_base(1, 12'h100);
    drive(4'b0010, 1'b1, 1);
    chk("sin_100", 16'(bus.rom_angle), 16'h0300);
    set_base(1, 12'h500);
    drive(4'b0010, 1'b1, 1);
    chk("sin_500", 16'(bus.rom_angle), 16'h0F00);
    set_base(1, 12'hC00);
    drive(4'b0010, 1'b1, 1);
    chk("sin_C00", 16'(bus.rom_angle), 16'h0800);
    sin_mask = '0;
    drive('0, 1'b1, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cos_arbiter.md
# cos_arbiter

Round-robin arbiter and sequencer that shares one combinational cosine lookup ROM (12-bit angle in, 16-bit result out) between `N_REQ` requesters. It accepts one tagged angle request per cycle over valid/ready, registers the angle onto the ROM address, and captures the ROM result into a response register that supports backpressure. It sits between the complex-number generators and the single `cos` table instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `ID_W`, 2: requester-index width; 2^ID_W >= N_REQ.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input N_REQ: per-requester request valid.
- `req_angle` input 12*N_REQ: flat bus; requester k uses bits [12k+11:12k].
- `req_ready` output N_REQ: at most one bit high; that requester's request is accepted this edge when its valid is also high.
- `req_sin` input N_REQ: present only with `COS_ARB_SIN_EN`; 1 = compute sin instead of cos.
- `rom_angle` output 12: registered ROM address.
- `rom_result` input 16: combinational ROM output for `rom_angle`.
- `resp_valid` output 1: response register holds data.
- `resp_ready` input 1: downstream consumes response this edge when both are high.
- `resp_data` output 16: ROM result.
- `resp_id` output ID_W: index of the originating requester.

## Operation
- Two stages: A = `rom_angle` plus `a_valid`/`a_id`; B = `resp_data`/`resp_id`/`resp_valid`.
- `b_load = a_valid && (!resp_valid || resp_ready)`; `a_load = !a_valid || b_load`.
- Arbitration is combinational over `req_valid`. Search starts at `last+1` and wraps modulo N_REQ; the first valid index wins.
- `req_ready[g]` = winner g && `a_load` && !rst. All other bits are 0. `req_ready` depends on `req_valid`; requesters must not make valid depend on ready.
- Acceptance loads `rom_angle <= req_angle[g]`, `a_id <= g`, `a_valid <= 1`, `last <= g`. `last` changes only on acceptance.
- On `a_load` with no acceptance, `a_valid <= 0` and `rom_angle` holds its value.
- On `b_load`: `resp_data <= rom_result`, `resp_id <= a_id`, `resp_valid <= 1`.
- Consumption without `b_load` gives `resp_valid <= 0`. Data and id hold their values.
- A granted requester must hold valid and angle stable until accepted.
- No request is dropped or reordered. Responses leave in acceptance order.

## Timing
- Reset values: `rom_angle`=0, `resp_valid`=0, `resp_data`=0, `resp_id`=0, `req_ready`=0 while `rst` is high, internal `a_valid`=0, `last`=N_REQ-1 (requester 0 has first priority).
- Reset in mid-operation flushes A and B. In-flight requests are lost and no response is emitted for them.
- Latency: request accepted at edge k gives `resp_valid` high from edge k+1, assuming no stall.
- Throughput is 1 request per cycle with `resp_ready` held high.
- Stall with `resp_valid && !resp_ready`:
  - If A is empty, one more request is accepted into A.
  - Once A is full, `req_ready` is all zero.
  - `rom_angle` and the B outputs hold stable.
- Simultaneous consume and refill of B in one edge keeps `resp_valid` high at full throughput.
- All requesters valid every cycle gives grant order 0,1,2,3,0,…
- A lone requester is granted every cycle.

## Configuration
- `COS_ARB_SIN_EN` defined:
  - `req_sin` port exists.
  - On acceptance with `req_sin[g]`=1, `rom_angle <= (12'h400 - req_angle[g])` modulo 2^12, using sin(a)=cos(90°−a) with 4096 units per turn.
  - Wrap is natural 12-bit, e.g. angle 12'hC00 gives 12'h800.
- `COS_ARB_SIN_EN` undefined: `req_sin` port is absent and angles pass to `rom_angle` unchanged.

## Test plan
- Reset: assert `rst` for 2 cycles with all requesters valid -> `req_ready`=0, `resp_valid`=0, `rom_angle`=0. After release, requester 0 is granted first.
- Single request: requester 2 sends angle 12'h123 with `resp_ready`=1 -> `rom_angle`=12'h123 after the acceptance edge. The next edge gives `resp_valid`=1, `resp_id`=2, `resp_data`=ROM(12'h123).
- Fairness: all 4 requesters continuously valid, angles 0x010·k -> response ids 0,1,2,3,0,1,… with one response per cycle and no gaps.
- Backpressure: hold `resp_ready`=0 for 5 cycles under full load -> exactly 2 acceptances (B, then A), then `req_ready`=0. Outputs are stable throughout. After release, ids continue in order with none lost.
- Reset mid-stream: assert `rst` with A and B full -> `resp_valid`=0 on the next edge. No stale response appears after release.
- With `COS_ARB_SIN_EN` defined: requester 1 sends sin, angle 12'h100 -> `rom_angle`=12'h300. Sin with angle 12'h500 -> `rom_angle`=12'hF00.
